// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array drain path.
// Provides the default column result width, the signed column data type
// and the ReLU clamp used when SA_DRAIN_RELU_EN is defined.
package sa_pkg;

    localparam int unsigned SA_DATA_WIDTH = 32;

    typedef logic signed [SA_DATA_WIDTH-1:0] sa_data_t;

    // Clamp negative values to zero.
    function automatic sa_data_t sa_relu(input sa_data_t v);
        return v[SA_DATA_WIDTH-1] ? sa_data_t'(0) : v;
    endfunction

endpackage

// File: rtl/sa_col_drain_if.sv
// Row writeback handshake between the drain stage and the NICE writeback logic.
//   out_valid : row available at FIFO head (master -> slave)
//   out_ready : consumer accepts the head row (slave -> master)
//   out_data  : head row, column c at [c*DATA_WIDTH +: DATA_WIDTH]
interface sa_col_drain_if
    import sa_pkg::*;
#(
    parameter int unsigned NUM_COLS   = 4,
    parameter int unsigned DATA_WIDTH = SA_DATA_WIDTH
);

    logic                           out_valid;
    logic                           out_ready;
    logic [NUM_COLS*DATA_WIDTH-1:0] out_data;

    modport master (output out_valid, output out_data, input  out_ready);
    modport slave  (input  out_valid, input  out_data, output out_ready);

endinterface

// File: rtl/sa_row_fifo.sv
// Synchronous row FIFO with registered head, count and full/empty flags.
// A write is accepted when not full, or when a read happens in the same cycle.
// clr_i flushes the FIFO and discards any same-cycle read or write.
// Storage is not reset; only pointers, count, flags and the head register are.
//   PE_clk, PE_rst_n : clock, async active-low reset
//   clr_i            : synchronous flush
//   wr_en_i/wr_data_i: write request and row
//   rd_en_i          : pop request (ignored when empty)
//   rd_data_o        : head row, zero when empty
//   cnt_o            : occupancy
//   full_o / empty_o : occupancy flags
module sa_row_fifo #(
    parameter  int unsigned WIDTH = 128,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = AW + 1
) (
    input  logic             PE_clk,
    input  logic             PE_rst_n,
    input  logic             clr_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic [CW-1:0]    cnt_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             full_q, empty_q;
    logic             rd_c, wr_c;

    // Accept rules, next count and next head row.
    always_comb begin
        rd_c   = rd_en_i & ~empty_q & ~clr_i;
        wr_c   = wr_en_i & (~full_q | rd_c) & ~clr_i;
        cnt_d  = cnt_q;
        head_d = head_q;
        if (clr_i)
            cnt_d = '0;
        else if (wr_c && !rd_c)
            cnt_d = cnt_q + CW'(1);
        else if (rd_c && !wr_c)
            cnt_d = cnt_q - CW'(1);
        // The head is registered so it can be presented without a read mux
        // on the output; a single remaining entry being popped must be
        // replaced by the row written in the same cycle.
        if (cnt_d == '0)
            head_d = '0;
        else if (rd_c)
            head_d = (cnt_q == CW'(1)) ? wr_data_i : mem_q[rd_ptr_q + AW'(1)];
        else if (cnt_q == '0)
            head_d = wr_data_i;
    end

    // Control state.
    always_ff @(posedge PE_clk or negedge PE_rst_n) begin
        if (!PE_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            head_q   <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (clr_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (wr_c) wr_ptr_q <= wr_ptr_q + AW'(1);
                if (rd_c) rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            cnt_q   <= cnt_d;
            head_q  <= head_d;
            full_q  <= (cnt_d == CW'(DEPTH));
            empty_q <= (cnt_d == '0);
        end
    end

    // Row storage.
    always_ff @(posedge PE_clk) begin
        if (wr_c) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign rd_data_o = head_q;
    assign cnt_o     = cnt_q;
    assign full_o    = full_q;
    assign empty_o   = empty_q;

endmodule

// File: rtl/sa_col_drain.sv
// Output drain stage below the systolic array's bottom PE row.
// Captures each column's partial sum one cycle after its enable, removes the
// one-cycle-per-column skew, packs aligned columns into a row and buffers
// rows in a FIFO that feeds the writeback handshake.
// Optional feature: define SA_DRAIN_RELU_EN to clamp negative column values
// to zero before they are written into the FIFO.
//   PE_clk, PE_rst_n : clock, async active-low reset
//   PE_mode          : 1 = weight-store mode, column samples ignored
//   clr              : synchronous flush of deskew lines, FIFO and error flags
//   col_en           : PE_en_left of each bottom-row PE
//   col_data         : packed PE_data_down, column c at [c*DATA_WIDTH +: DATA_WIDTH]
//   drain_if         : out_valid / out_ready / out_data row handshake
//   fifo_cnt         : FIFO occupancy
//   ovf_err          : sticky, a row was dropped on a full FIFO
//   skew_err         : sticky, an aligned row had only some columns valid
module sa_col_drain
    import sa_pkg::*;
#(
    parameter int unsigned NUM_COLS   = 4,
    parameter int unsigned DATA_WIDTH = SA_DATA_WIDTH,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                           PE_clk,
    input  logic                           PE_rst_n,
    input  logic                           PE_mode,
    input  logic                           clr,
    input  logic [NUM_COLS-1:0]            col_en,
    input  logic [NUM_COLS*DATA_WIDTH-1:0] col_data,
    sa_col_drain_if.master                 drain_if,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_cnt,
    output logic                           ovf_err,
    output logic                           skew_err
);

    localparam int unsigned ROW_W = NUM_COLS * DATA_WIDTH;

    logic [NUM_COLS-1:0] en_q;
    logic [NUM_COLS-1:0] al_vld;
    logic [ROW_W-1:0]    al_data;
    logic [ROW_W-1:0]    row_data;
    logic                row_all, row_any;
    logic                fifo_full, fifo_empty, rd_c;

    // Deskew: column c is delayed NUM_COLS-1-c cycles after capture so every
    // column of a row lines up with the last column's capture cycle.
    for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
        localparam int unsigned DLY = NUM_COLS - 1 - c;
        if (DLY == 0) begin : g_pass
            assign al_vld[c]                           = en_q[c];
            assign al_data[c*DATA_WIDTH +: DATA_WIDTH] = col_data[c*DATA_WIDTH +: DATA_WIDTH];
        end else begin : g_dly
            logic [DLY-1:0]        vld_q;
            logic [DATA_WIDTH-1:0] dat_q [DLY];

            always_ff @(posedge PE_clk or negedge PE_rst_n) begin
                if (!PE_rst_n) begin
                    vld_q <= '0;
                end else if (clr) begin
                    vld_q <= '0;
                end else begin
                    vld_q[0] <= en_q[c];
                    for (int s = 1; s < DLY; s++) vld_q[s] <= vld_q[s-1];
                end
            end

            // Data follows its valid bit; no reset needed.
            always_ff @(posedge PE_clk) begin
                dat_q[0] <= col_data[c*DATA_WIDTH +: DATA_WIDTH];
                for (int s = 1; s < DLY; s++) dat_q[s] <= dat_q[s-1];
            end

            assign al_vld[c]                           = vld_q[DLY-1];
            assign al_data[c*DATA_WIDTH +: DATA_WIDTH] = dat_q[DLY-1];
        end
    end

`ifdef SA_DRAIN_RELU_EN
    // Clamp each aligned column before it enters the FIFO.
    for (genvar c = 0; c < NUM_COLS; c++) begin : g_relu
        if (DATA_WIDTH == SA_DATA_WIDTH) begin : g_pkg
            assign row_data[c*DATA_WIDTH +: DATA_WIDTH] = sa_relu(al_data[c*DATA_WIDTH +: DATA_WIDTH]);
        end else begin : g_gen
            assign row_data[c*DATA_WIDTH +: DATA_WIDTH] =
                al_data[c*DATA_WIDTH + DATA_WIDTH - 1] ? '0 : al_data[c*DATA_WIDTH +: DATA_WIDTH];
        end
    end
`else
    assign row_data = al_data;
`endif

    assign row_all = &al_vld;
    assign row_any = |al_vld;
    assign rd_c    = drain_if.out_valid & drain_if.out_ready;

    // Capture enables and sticky error flags.
    always_ff @(posedge PE_clk or negedge PE_rst_n) begin
        if (!PE_rst_n) begin
            en_q     <= '0;
            ovf_err  <= 1'b0;
            skew_err <= 1'b0;
        end else if (clr) begin
            en_q     <= '0;
            ovf_err  <= 1'b0;
            skew_err <= 1'b0;
        end else begin
            en_q <= col_en & ~{NUM_COLS{PE_mode}};
            if (row_all && fifo_full && !rd_c) ovf_err  <= 1'b1;
            if (row_any && !row_all)           skew_err <= 1'b1;
        end
    end

    sa_row_fifo #(
        .WIDTH (ROW_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .PE_clk    (PE_clk),
        .PE_rst_n  (PE_rst_n),
        .clr_i     (clr),
        .wr_en_i   (row_all),
        .wr_data_i (row_data),
        .rd_en_i   (drain_if.out_ready),
        .rd_data_o (drain_if.out_data),
        .cnt_o     (fifo_cnt),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    assign drain_if.out_valid = ~fifo_empty;

endmodule

// File: tb/tb_sa_col_drain.sv
// Directed bench for sa_col_drain: table-driven row vectors plus
// hand-written sequences for overflow, full-with-read, mode gating,
// clr and asynchronous reset.
module tb_sa_col_drain;

    localparam int unsigned NC = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned FD = 4;
    localparam int unsigned RW = NC * DW;

`ifdef SA_DRAIN_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pe_mode = 1'b0;
    logic          clr = 1'b0;
    logic          out_ready = 1'b0;
    logic [NC-1:0] col_en = '0;
    logic [RW-1:0] col_data = '0;
    logic [2:0]    fifo_cnt;
    logic          ovf_err, skew_err, out_valid;
    logic [RW-1:0] out_data;

    sa_col_drain_if #(.NUM_COLS(NC), .DATA_WIDTH(DW)) dif ();
    assign dif.out_ready = out_ready;
    assign out_valid     = dif.out_valid;
    assign out_data      = dif.out_data;

    sa_col_drain #(
        .NUM_COLS   (NC),
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (FD)
    ) dut (
        .PE_clk   (clk),
        .PE_rst_n (rst_n),
        .PE_mode  (pe_mode),
        .clr      (clr),
        .col_en   (col_en),
        .col_data (col_data),
        .drain_if (dif),
        .fifo_cnt (fifo_cnt),
        .ovf_err  (ovf_err),
        .skew_err (skew_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [RW-1:0] popq[$];
    logic [RW-1:0] row_buf [8];
    logic [31:0]   vld_trace;
    int            snap_cnt, snap_vld, snap_ovf, snap_skew;

    // Record every row the consumer accepts.
    always @(negedge clk) begin
        if (rst_n && !clr && out_valid && out_ready) popq.push_back(out_data);
    end

    task automatic chk_i(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_w(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pop_chk(input string name, input logic [RW-1:0] exp);
        if (popq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got no row expected %h", name, exp);
        end else begin
            chk_w(name, popq.pop_front(), exp);
        end
    endtask

    // Drive n skewed rows back to back from row_buf. Column c of row r is
    // enabled in cycle r+c and carries its data one cycle later.
    // mode_from: first cycle with PE_mode=1 (-1 never); rdy_t: cycle forcing
    // out_ready=1 (-1 none); clr_t: cycle pulsing clr (-1 none).
    task automatic drive_rows(input int n, input int extra, input int mode_from,
                              input logic rdy_dflt, input int rdy_t, input int clr_t);
        for (int t = 0; t < n + int'(NC) + extra; t++) begin
            @(posedge clk);
            #1;
            pe_mode   = (mode_from >= 0) && (t >= mode_from);
            out_ready = (t == rdy_t) ? 1'b1 : rdy_dflt;
            clr       = (t == clr_t);
            for (int c = 0; c < int'(NC); c++) begin
                col_en[c] = (t - c >= 0) && (t - c < n);
                if ((t - c - 1 >= 0) && (t - c - 1 < n))
                    col_data[c*DW +: DW] = row_buf[t-c-1][c*DW +: DW];
                else
                    col_data[c*DW +: DW] = '0;
            end
            @(negedge clk);
            if (t < 32) vld_trace[t] = out_valid;
            if (t == clr_t + 1) begin
                snap_cnt  = int'(fifo_cnt);
                snap_vld  = int'(out_valid);
                snap_ovf  = int'(ovf_err);
                snap_skew = int'(skew_err);
            end
        end
        @(posedge clk);
        #1;
        pe_mode  = 1'b0;
        clr      = 1'b0;
        col_en   = '0;
        col_data = '0;
    endtask

    typedef struct {
        string         name;
        logic [RW-1:0] din;
        logic [RW-1:0] exp_plain;
        logic [RW-1:0] exp_relu;
    } vec_t;

    vec_t vecs [5];

    initial begin
        vecs[0] = '{"vec_ramp",
                    {32'd4, 32'd3, 32'd2, 32'd1},
                    {32'd4, 32'd3, 32'd2, 32'd1},
                    {32'd4, 32'd3, 32'd2, 32'd1}};
        vecs[1] = '{"vec_neg10",
                    {32'h7FFF_FFFF, 32'h0, 32'd7, 32'hFFFF_FFF6},
                    {32'h7FFF_FFFF, 32'h0, 32'd7, 32'hFFFF_FFF6},
                    {32'h7FFF_FFFF, 32'h0, 32'd7, 32'h0}};
        vecs[2] = '{"vec_extremes",
                    {32'hDEAD_BEEF, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000},
                    {32'hDEAD_BEEF, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000},
                    {32'h0, 32'd1, 32'h0, 32'h0}};
        vecs[3] = '{"vec_zero", '0, '0, '0};
        vecs[4] = '{"vec_allneg",
                    {4{32'hFFFF_FFF6}},
                    {4{32'hFFFF_FFF6}},
                    '0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk_i("rst_valid", int'(out_valid), 0);
        chk_w("rst_data", out_data, '0);
        chk_i("rst_cnt", int'(fifo_cnt), 0);
        chk_i("rst_ovf", int'(ovf_err), 0);
        chk_i("rst_skew", int'(skew_err), 0);

        // Basic skewed row: out_valid for exactly one cycle, 5 after col 0 enable
        vld_trace  = '0;
        row_buf[0] = {32'd4, 32'd3, 32'd2, 32'd1};
        drive_rows(1, 4, -1, 1'b1, -1, -1);
        chk_i("basic_valid_trace", int'(vld_trace[8:0]), 32);
        pop_chk("basic_row", {32'd4, 32'd3, 32'd2, 32'd1});
        chk_i("basic_cnt_end", int'(fifo_cnt), 0);

        // Table-driven single rows, including sign handling
        for (int i = 0; i < 5; i++) begin
            row_buf[0] = vecs[i].din;
            drive_rows(1, 2, -1, 1'b1, -1, -1);
            pop_chk(vecs[i].name, RELU ? vecs[i].exp_relu : vecs[i].exp_plain);
        end
        chk_i("vec_no_extra", popq.size(), 0);

        // Overflow: five rows into a four-entry FIFO with no consumer
        for (int k = 0; k < 5; k++)
            for (int c = 0; c < int'(NC); c++)
                row_buf[k][c*DW +: DW] = DW'(16 * (k + 1) + c);
        drive_rows(5, 2, -1, 1'b0, -1, -1);
        chk_i("ovf_cnt", int'(fifo_cnt), 4);
        chk_i("ovf_flag", int'(ovf_err), 1);
        chk_w("ovf_head", out_data, row_buf[0]);
        drive_rows(0, 2, -1, 1'b1, -1, -1);
        for (int k = 0; k < 4; k++) pop_chk("ovf_drain_row", row_buf[k]);
        chk_i("ovf_row5_absent", popq.size(), 0);
        chk_i("ovf_cnt_empty", int'(fifo_cnt), 0);

        // Full FIFO with a read in the aligned cycle of a fifth row
        drive_rows(0, 0, -1, 1'b0, -1, 0);
        chk_i("clr_ovf_cleared", int'(ovf_err), 0);
        for (int k = 0; k < 5; k++)
            for (int c = 0; c < int'(NC); c++)
                row_buf[k][c*DW +: DW] = DW'(256 * (k + 1) + c);
        drive_rows(4, 1, -1, 1'b0, -1, -1);
        chk_i("full_cnt", int'(fifo_cnt), 4);
        row_buf[5] = row_buf[4];
        row_buf[4] = row_buf[0];
        row_buf[0] = row_buf[5];
        drive_rows(1, 1, -1, 1'b0, 4, -1);
        chk_i("fullrd_cnt", int'(fifo_cnt), 4);
        chk_i("fullrd_ovf", int'(ovf_err), 0);
        pop_chk("fullrd_pop_a", row_buf[4]);
        drive_rows(0, 2, -1, 1'b1, -1, -1);
        pop_chk("fullrd_b", row_buf[1]);
        pop_chk("fullrd_c", row_buf[2]);
        pop_chk("fullrd_d", row_buf[3]);
        pop_chk("fullrd_e", row_buf[0]);
        chk_i("fullrd_empty", popq.size(), 0);

        // Mode gating: enables ignored in weight-store mode
        row_buf[0] = {32'd11, 32'd12, 32'd13, 32'd14};
        row_buf[1] = {32'd21, 32'd22, 32'd23, 32'd24};
        drive_rows(2, 2, 0, 1'b0, -1, -1);
        chk_i("mode_cnt", int'(fifo_cnt), 0);
        chk_i("mode_skew", int'(skew_err), 0);
        chk_i("mode_ovf", int'(ovf_err), 0);
        // PE_mode rises after columns 0-1 are captured
        drive_rows(1, 2, 2, 1'b0, -1, -1);
        chk_i("midmode_skew", int'(skew_err), 1);
        chk_i("midmode_cnt", int'(fifo_cnt), 0);
        chk_i("midmode_valid", int'(out_valid), 0);

        // clr with two rows queued and one row in the deskew lines
        drive_rows(2, 1, -1, 1'b0, -1, -1);
        chk_i("clr_pre_cnt", int'(fifo_cnt), 2);
        row_buf[0] = {32'd31, 32'd32, 32'd33, 32'd34};
        drive_rows(1, 3, -1, 1'b0, -1, 3);
        chk_i("clr_next_cnt", snap_cnt, 0);
        chk_i("clr_next_valid", snap_vld, 0);
        chk_i("clr_next_skew", snap_skew, 0);
        chk_i("clr_next_ovf", snap_ovf, 0);
        chk_i("clr_after_cnt", int'(fifo_cnt), 0);
        chk_i("clr_after_skew", int'(skew_err), 0);

        // Asynchronous reset in the middle of a row
        drive_rows(1, 1, -1, 1'b0, -1, -1);
        chk_i("rstmid_pre_cnt", int'(fifo_cnt), 1);
        fork
            drive_rows(1, 2, -1, 1'b0, -1, -1);
            begin
                repeat (2) @(posedge clk);
                #3;
                rst_n = 1'b0;
                #1;
                chk_i("rstmid_async_valid", int'(out_valid), 0);
                chk_i("rstmid_async_cnt", int'(fifo_cnt), 0);
                chk_w("rstmid_async_data", out_data, '0);
                repeat (4) @(negedge clk);
                rst_n = 1'b1;
            end
        join
        chk_i("rstmid_cnt", int'(fifo_cnt), 0);
        chk_i("rstmid_valid", int'(out_valid), 0);
        chk_i("rstmid_skew", int'(skew_err), 0);
        chk_i("rstmid_no_rows", popq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
